// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Owner encoding, requester index constants and the default burst limit.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic IDX_P0 = 1'b0;
  localparam logic IDX_P1 = 1'b1;

  localparam int DEFAULT_MAXBURST = 16;

  function automatic owner_t owner_of(input logic idx);
    return (idx == IDX_P1) ? OWN_P1 : OWN_P0;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for the RAM arbiter.
// Contention policy: round-robin when RAM_ARB_ROUND_ROBIN_EN is defined, else requester 0 wins.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int MAXBURST = DEFAULT_MAXBURST,
  parameter int CNTW     = $clog2(MAXBURST + 1)
) (
  input  logic            req0,
  input  logic            req1,
  input  logic            lock0,
  input  logic            lock1,
  input  owner_t          owner,
  input  logic [CNTW-1:0] cnt,
  input  logic            last,
  output logic            valid,
  output logic            idx,
  output logic            cont
);

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXBURST);

  logic room;
  logic tie_idx;

  assign room = (cnt < CNT_MAX);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // On contention the requester that did not win last time goes first.
  assign tie_idx = ~last;
`else
  logic unused_last;
  assign unused_last = last;
  assign tie_idx     = IDX_P0;
`endif

  always_comb begin
    valid = 1'b0;
    idx   = IDX_P0;
    cont  = 1'b0;
    if (owner == OWN_P0 && req0 && lock0 && room) begin
      valid = 1'b1;
      idx   = IDX_P0;
      cont  = 1'b1;
    end else if (owner == OWN_P1 && req1 && lock1 && room) begin
      valid = 1'b1;
      idx   = IDX_P1;
      cont  = 1'b1;
    end else if (req0 && req1) begin
      valid = 1'b1;
      idx   = tie_idx;
    end else if (req0) begin
      valid = 1'b1;
      idx   = IDX_P0;
    end else if (req1) begin
      valid = 1'b1;
      idx   = IDX_P1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter onto one synchronous single-port RAM, with locked bursts bounded by MAXBURST.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin contention (default: fixed priority to requester 0).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRW    = 32,
  parameter int MAXBURST = DEFAULT_MAXBURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic             we0,
  input  logic             we1,
  input  logic [ADDRW-1:0] addr0,
  input  logic [ADDRW-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic             ram_en,
  output logic             ram_we,
  output logic [ADDRW-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam int CNTW = $clog2(MAXBURST + 1);

  // Handshake: a requester holds reqN (and its addr/we/wdata) until gntN is
  // seen high in the same cycle; that cycle is the transfer. Reads return
  // exactly one cycle later on rvalidN, which has no back-pressure.

  owner_t          owner_q, owner_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [1:0]      rsel_q, rsel_d;

  logic pick_valid;
  logic pick_idx;
  logic pick_cont;
  logic win;
  logic g_lock;
  logic g_we;

  ram_arb_pick #(
    .MAXBURST (MAXBURST),
    .CNTW     (CNTW)
  ) u_pick (
    .req0  (req0),
    .req1  (req1),
    .lock0 (lock0),
    .lock1 (lock1),
    .owner (owner_q),
    .cnt   (cnt_q),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx),
    .cont  (pick_cont)
  );

  // Reset suppresses the grant combinationally so nothing reaches the RAM.
  assign win    = pick_valid & ~rst;
  assign g_lock = (pick_idx == IDX_P1) ? lock1 : lock0;
  assign g_we   = (pick_idx == IDX_P1) ? we1 : we0;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      last_q  <= IDX_P1;
      rsel_q  <= 2'b00;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rsel_q  <= rsel_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    cnt_d   = '0;
    last_d  = last_q;
    rsel_d  = 2'b00;
    if (win) begin
      last_d  = pick_idx;
      owner_d = g_lock ? owner_of(pick_idx) : OWN_NONE;
      cnt_d   = pick_cont ? cnt_q + 1'b1 : CNTW'(1);
      if (!g_we) begin
        rsel_d = (pick_idx == IDX_P1) ? 2'b10 : 2'b01;
      end
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (win) begin
      ram_en = 1'b1;
      if (pick_idx == IDX_P1) begin
        gnt1      = 1'b1;
        ram_we    = we1;
        ram_addr  = addr1;
        ram_wdata = wdata1;
      end else begin
        gnt0      = 1'b1;
        ram_we    = we0;
        ram_addr  = addr0;
        ram_wdata = wdata0;
      end
    end
  end

  // A read in flight when reset arrives must not surface its strobe.
  assign rvalid0 = rsel_q[0] & ~rst;
  assign rvalid1 = rsel_q[1] & ~rst;
  assign rdata0  = ram_rdata;
  assign rdata1  = ram_rdata;

endmodule
